// File: rtl/ihex_pkg.sv
// Shared encodings for the Intel-HEX beat decoder: FSM states, record types,
// error causes and the record-type/length legality rule.
package ihex_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PARSE = 2'd1,
    ST_CHECK = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  localparam logic [7:0] REC_DATA      = 8'h00;
  localparam logic [7:0] REC_EOF       = 8'h01;
  localparam logic [7:0] REC_EXT_SEG   = 8'h02;
  localparam logic [7:0] REC_START_SEG = 8'h03;
  localparam logic [7:0] REC_EXT_LIN   = 8'h04;
  localparam logic [7:0] REC_START_LIN = 8'h05;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BAD_CHAR = 3'd1;
  localparam logic [2:0] ERR_COUNT    = 3'd2;
  localparam logic [2:0] ERR_CHECKSUM = 3'd3;
  localparam logic [2:0] ERR_LENGTH   = 3'd4;
  localparam logic [2:0] ERR_TYPE     = 3'd5;
  localparam logic [2:0] ERR_SHORT    = 3'd6;

  function automatic logic type_len_ok(input logic [7:0] rtype, input logic [7:0] len);
    case (rtype)
      REC_DATA:                     return 1'b1;
      REC_EOF:                      return len == 8'd0;
      REC_EXT_SEG, REC_EXT_LIN:     return len == 8'd2;
      REC_START_SEG, REC_START_LIN: return len == 8'd4;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ihex_char_decode.sv
// Combinational ASCII classifier: hex digit (either case) to nibble, colon, CR/LF.
module ihex_char_decode (
  input  logic [7:0] ch,
  output logic       is_hex,
  output logic [3:0] nibble,
  output logic       is_colon,
  output logic       is_newline
);

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      is_hex = 1'b1;
      nibble = 4'(ch - 8'h30);
    end else if (ch >= 8'h41 && ch <= 8'h46) begin
      is_hex = 1'b1;
      nibble = 4'(ch - 8'h37);
    end else if (ch >= 8'h61 && ch <= 8'h66) begin
      is_hex = 1'b1;
      nibble = 4'(ch - 8'h57);
    end
  end

  assign is_colon   = (ch == 8'h3A);
  assign is_newline = (ch == 8'h0D) || (ch == 8'h0A);

endmodule

// File: rtl/ihex_beat_decoder.sv
// Intel-HEX line decoder: parses ASCII records, validates them and emits the
// data payload as aligned, byte-enabled write beats.
module ihex_beat_decoder
  import ihex_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int MAX_RECORD = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    we_in,
  input  logic [7:0]              data_in,
  output logic                    ready_in,
  output logic                    we_out,
  output logic [8*DATA_BYTES-1:0] data_out,
  output logic [DATA_BYTES-1:0]   be_out,
  output logic [31:0]             address_out,
  input  logic                    write_done,
  output logic [31:0]             start_address,
  output logic                    start_valid,
  output logic                    end_of_file,
  output logic                    line_error,
  output logic [2:0]              error_code,
  output logic [15:0]             record_count,
  output logic [1:0]              state_dbg
);

  localparam int          IW        = (MAX_RECORD > 1) ? $clog2(MAX_RECORD) : 1;
  localparam logic [8:0]  MAXR      = 9'(MAX_RECORD);
  localparam logic [31:0] LANE_MASK = 32'(DATA_BYTES - 1);

  state_t      state;
  logic [7:0]  rec_buf [MAX_RECORD];
  logic [7:0]  val [4];
  logic [7:0]  rec_len, rec_type, sum;
  logic [15:0] rec_addr;
  logic [3:0]  hi_nib;
  logic        half, bad;
  logic [8:0]  byte_cnt;
  logic [31:0] offset;
  logic [10:0] base;

  logic       c_hex, c_colon, c_newline;
  logic [3:0] c_nib;

  ihex_char_decode u_char (
    .ch        (data_in),
    .is_hex    (c_hex),
    .nibble    (c_nib),
    .is_colon  (c_colon),
    .is_newline(c_newline)
  );

  logic       take;
  logic [7:0] cur_byte;
  logic [8:0] data_idx;

  assign ready_in  = (state == ST_IDLE) || (state == ST_PARSE);
  assign take      = we_in && ready_in;
  assign cur_byte  = {hi_nib, c_nib};
  assign data_idx  = byte_cnt - 9'd4;
  assign state_dbg = state;

  logic [2:0] err;
  always_comb begin
    if (bad)                                              err = ERR_BAD_CHAR;
    else if (byte_cnt < 9'd4)                             err = ERR_SHORT;
    else if ({1'b0, rec_len} > MAXR || byte_cnt > MAXR + 9'd5) err = ERR_LENGTH;
    else if (half || byte_cnt != {1'b0, rec_len} + 9'd5)  err = ERR_COUNT;
    else if (sum != 8'd0)                                 err = ERR_CHECKSUM;
    else if (!type_len_ok(rec_type, rec_len))             err = ERR_TYPE;
    else                                                  err = ERR_NONE;
  end

  // base = record-byte index sitting in lane 0 of a beat (negative on the first beat).
  logic [31:0] abs_addr;
  logic [10:0] lane_off, first_base, sel_base, pos;
  logic [8*DATA_BYTES-1:0] nxt_data;
  logic [DATA_BYTES-1:0]   nxt_be;

  assign abs_addr   = offset + {16'h0, rec_addr};
  assign lane_off   = abs_addr[10:0] & LANE_MASK[10:0];
  assign first_base = 11'd0 - lane_off;

  always_comb begin
    sel_base = (state == ST_WRITE) ? base + 11'(DATA_BYTES) : first_base;
    nxt_data = '0;
    nxt_be   = '0;
    pos      = '0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      pos = sel_base + 11'(k);
      if (!pos[10] && pos < {3'b000, rec_len}) begin
        nxt_be[k]          = 1'b1;
        nxt_data[8*k +: 8] = rec_buf[pos[IW-1:0]];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      we_out        <= 1'b0;
      data_out      <= '0;
      be_out        <= '0;
      address_out   <= '0;
      start_address <= '0;
      start_valid   <= 1'b0;
      end_of_file   <= 1'b0;
      line_error    <= 1'b0;
      error_code    <= ERR_NONE;
      record_count  <= '0;
      offset        <= '0;
      sum           <= '0;
      byte_cnt      <= '0;
      half          <= 1'b0;
      bad           <= 1'b0;
      hi_nib        <= '0;
      rec_len       <= '0;
      rec_type      <= '0;
      rec_addr      <= '0;
      base          <= '0;
    end else begin
      end_of_file <= 1'b0;
      line_error  <= 1'b0;
      case (state)
        ST_IDLE: if (take && c_colon) begin
          sum      <= '0;
          byte_cnt <= '0;
          half     <= 1'b0;
          bad      <= 1'b0;
          state    <= ST_PARSE;
        end
        ST_PARSE: if (take) begin
          if (c_newline) state <= ST_CHECK;
          else if (c_hex) begin
            if (!half) begin
              hi_nib <= c_nib;
              half   <= 1'b1;
            end else begin
              half <= 1'b0;
              sum  <= sum + cur_byte;
              if (byte_cnt != 9'h1FF) byte_cnt <= byte_cnt + 9'd1;
              case (byte_cnt)
                9'd0:    rec_len         <= cur_byte;
                9'd1:    rec_addr[15:8]  <= cur_byte;
                9'd2:    rec_addr[7:0]   <= cur_byte;
                9'd3:    rec_type        <= cur_byte;
                default: begin
                  // The checksum byte lands here too; it is never read back.
                  if (data_idx < MAXR) rec_buf[data_idx[IW-1:0]] <= cur_byte;
                  if (data_idx < 9'd4) val[data_idx[1:0]] <= cur_byte;
                end
              endcase
            end
          end else bad <= 1'b1;
        end
        ST_CHECK: begin
          state <= ST_IDLE;
          if (err != ERR_NONE) begin
            line_error <= 1'b1;
            error_code <= err;
          end else begin
            record_count <= record_count + 16'd1;
            case (rec_type)
              REC_DATA: if (rec_len != 8'd0) begin
                state       <= ST_WRITE;
                we_out      <= 1'b1;
                address_out <= abs_addr & ~LANE_MASK;
                data_out    <= nxt_data;
                be_out      <= nxt_be;
                base        <= first_base;
              end
              REC_EOF: begin
                end_of_file   <= 1'b1;
                offset        <= '0;
                start_address <= '0;
                start_valid   <= 1'b0;
              end
              REC_EXT_SEG: offset <= {12'h0, val[0], val[1], 4'h0};
              REC_START_SEG: begin
                start_address <= {12'h0, val[0], val[1], 4'h0} + {16'h0, val[2], val[3]};
                start_valid   <= 1'b1;
              end
              REC_EXT_LIN: offset <= {val[0], val[1], 16'h0};
              REC_START_LIN: begin
                start_address <= {val[0], val[1], val[2], val[3]};
                start_valid   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_WRITE: if (write_done) begin
          if (nxt_be == '0) begin
            we_out   <= 1'b0;
            data_out <= '0;
            be_out   <= '0;
            state    <= ST_IDLE;
          end else begin
            base        <= sel_base;
            address_out <= address_out + 32'(DATA_BYTES);
            data_out    <= nxt_data;
            be_out      <= nxt_be;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ihex_beat_decoder.sv
// Directed bench for ihex_beat_decoder (DATA_BYTES=4, MAX_RECORD=16): a table of
// HEX lines with hand-computed outcomes, plus stall and mid-write reset sequences.
module tb_ihex_beat_decoder;

  localparam int DB = 4;

  logic        clock = 1'b0;
  logic        reset, we_in, write_done;
  logic [7:0]  data_in;
  logic        ready_in, we_out, start_valid, end_of_file, line_error;
  logic [31:0] data_out, address_out, start_address;
  logic [3:0]  be_out;
  logic [2:0]  error_code;
  logic [15:0] record_count;
  logic [1:0]  state_dbg;

  always #5 clock = ~clock;

  ihex_beat_decoder #(.DATA_BYTES(DB), .MAX_RECORD(16)) dut (
    .clock(clock), .reset(reset), .we_in(we_in), .data_in(data_in), .ready_in(ready_in),
    .we_out(we_out), .data_out(data_out), .be_out(be_out), .address_out(address_out),
    .write_done(write_done), .start_address(start_address), .start_valid(start_valid),
    .end_of_file(end_of_file), .line_error(line_error), .error_code(error_code),
    .record_count(record_count), .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;
  logic [67:0] exp_q[$];   // {address, be, data}

  typedef struct {
    string       line;
    logic [2:0]  err;
    logic        eof;
    logic        sv;
    logic [31:0] sa;
    int          nb;
    logic [67:0] b0;
    logic [67:0] b1;
  } vec_t;
  vec_t vecs[$];

  int         exp_count = 0;
  logic [2:0] last_err = 3'd0;
  logic       seen_err, seen_eof;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [67:0] beat(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    return {a, b, d};
  endfunction

  task automatic add(input string l, input logic [2:0] e, input logic eof, input logic sv,
                     input logic [31:0] sa, input int nb, input logic [67:0] b0, input logic [67:0] b1);
    vec_t v;
    v.line = l; v.err = e; v.eof = eof; v.sv = sv; v.sa = sa; v.nb = nb; v.b0 = b0; v.b1 = b1;
    vecs.push_back(v);
  endtask

  // One character per cycle, waiting (bounded) for ready_in before each.
  task automatic send_line(input string l);
    for (int i = 0; i < l.len(); i++) begin
      for (int w = 0; w < 20 && !ready_in; w++) @(negedge clock);
      if (!ready_in) chk("ready_wait", 68'(ready_in), 68'd1);
      we_in   = 1'b1;
      data_in = l[i];
      @(negedge clock);
      we_in   = 1'b0;
    end
  endtask

  // Watch outputs after a line: record pulses, check and acknowledge beats.
  task automatic collect();
    logic done_ok;
    done_ok  = 1'b0;
    seen_err = 1'b0;
    seen_eof = 1'b0;
    for (int c = 0; c < 80; c++) begin
      write_done = 1'b0;
      if (line_error) seen_err = 1'b1;
      if (end_of_file) seen_eof = 1'b1;
      if (we_out) begin
        chk("beat_expected", 68'(exp_q.size() > 0), 68'd1);
        if (exp_q.size() > 0) chk("beat", {address_out, be_out, data_out}, exp_q.pop_front());
        write_done = 1'b1;
      end else if (c > 0 && ready_in) begin
        done_ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    write_done = 1'b0;
    chk("idle_timeout", 68'(done_ok), 68'd1);
  endtask

  initial begin
    string long_line;
    logic [67:0] held;

    reset = 1'b1; we_in = 1'b0; data_in = 8'h00; write_done = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_ready_in", 68'(ready_in), 68'd1);
    chk("rst_we_out", 68'(we_out), 68'd0);
    chk("rst_beat", {address_out, be_out, data_out}, 68'd0);
    chk("rst_start", {start_valid, start_address}, 68'd0);
    chk("rst_pulses", {end_of_file, line_error}, 68'd0);
    chk("rst_error_code", 68'(error_code), 68'd0);
    chk("rst_record_count", 68'(record_count), 68'd0);
    reset = 1'b0;
    @(negedge clock);

    long_line = ":20000000";
    for (int i = 0; i < 32; i++) long_line = {long_line, "00"};
    long_line = {long_line, "E0\n"};

    add("zz:0400100001020304E2\n", 3'd0, 0, 0, 32'h0, 1, beat(32'h10, 4'hF, 32'h04030201), '0);
    add(":03001200A0B0C0DB\n",     3'd0, 0, 0, 32'h0, 2, beat(32'h10, 4'hC, 32'hB0A00000), beat(32'h14, 4'h1, 32'h000000C0));
    add(":0400100001020304E3\n",   3'd3, 0, 0, 32'h0, 0, '0, '0);
    add(":020000041234B4\n",       3'd0, 0, 0, 32'h0, 0, '0, '0);
    add(":0100000055AA\015",       3'd0, 0, 0, 32'h0, 1, beat(32'h12340000, 4'h1, 32'h00000055), '0);
    add(":020000021000EC\n",       3'd0, 0, 0, 32'h0, 0, '0, '0);
    add(":02FFFF00AABB9B\n",       3'd0, 0, 0, 32'h0, 2, beat(32'h0001FFFC, 4'h8, 32'hAA000000), beat(32'h00020000, 4'h1, 32'h000000BB));
    add(":0400000500001234B1\n",   3'd0, 0, 1, 32'h00001234, 0, '0, '0);
    add(":0400000312345678E5\n",   3'd0, 0, 1, 32'h000179B8, 0, '0, '0);
    add(":02000004abcd82\n",       3'd0, 0, 1, 32'h000179B8, 0, '0, '0);
    add(":010004006695\n",         3'd0, 0, 1, 32'h000179B8, 1, beat(32'hABCD0004, 4'h1, 32'h00000066), '0);
    add(":0400G000\n",             3'd1, 0, 1, 32'h000179B8, 0, '0, '0);
    add(":0400\n",                 3'd6, 0, 1, 32'h000179B8, 0, '0, '0);
    add(":0400100001020304\n",     3'd2, 0, 1, 32'h000179B8, 0, '0, '0);
    add(":0100000255A8\n",         3'd5, 0, 1, 32'h000179B8, 0, '0, '0);
    add(":00000006FA\n",           3'd5, 0, 1, 32'h000179B8, 0, '0, '0);
    add(long_line,                 3'd4, 0, 1, 32'h000179B8, 0, '0, '0);
    add(":0000000000\n",           3'd0, 0, 1, 32'h000179B8, 0, '0, '0);
    add(":00000001FF\n",           3'd0, 1, 0, 32'h0, 0, '0, '0);
    add(":010000007788\n",         3'd0, 0, 0, 32'h0, 1, beat(32'h0, 4'h1, 32'h00000077), '0);

    foreach (vecs[n]) begin
      if (vecs[n].nb > 0) exp_q.push_back(vecs[n].b0);
      if (vecs[n].nb > 1) exp_q.push_back(vecs[n].b1);
      if (vecs[n].err != 3'd0) last_err = vecs[n].err;
      else exp_count++;
      send_line(vecs[n].line);
      collect();
      chk($sformatf("v%0d_line_error", n), 68'(seen_err), 68'(vecs[n].err != 3'd0));
      chk($sformatf("v%0d_error_code", n), 68'(error_code), 68'(last_err));
      chk($sformatf("v%0d_eof", n), 68'(seen_eof), 68'(vecs[n].eof));
      chk($sformatf("v%0d_record_count", n), 68'(record_count), 68'(exp_count));
      chk($sformatf("v%0d_start", n), {start_valid, start_address}, {vecs[n].sv, vecs[n].sa});
      chk($sformatf("v%0d_beats_left", n), 68'(exp_q.size()), 68'd0);
      exp_q.delete();
    end

    // Stalled sink: beat must hold while write_done is low; write_done is
    // also held high while the line streams in, where it must be ignored.
    write_done = 1'b1;
    send_line(":0400100001020304E2\n");
    write_done = 1'b0;
    for (int c = 0; c < 10 && !we_out; c++) @(negedge clock);
    chk("stall_we_out", 68'(we_out), 68'd1);
    held = {address_out, be_out, data_out};
    chk("stall_beat", held, beat(32'h10, 4'hF, 32'h04030201));
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_stable", {address_out, be_out, data_out}, held);
      chk("stall_ready_low", 68'(ready_in), 68'd0);
      chk("stall_we_held", 68'(we_out), 68'd1);
    end
    write_done = 1'b1;
    @(negedge clock);
    write_done = 1'b0;
    chk("stall_release_we_out", 68'(we_out), 68'd0);
    chk("stall_release_ready", 68'(ready_in), 68'd1);
    exp_count++;
    chk("stall_record_count", 68'(record_count), 68'(exp_count));

    // Reset during the first of two beats.
    send_line(":03001200A0B0C0DB\n");
    for (int c = 0; c < 10 && !we_out; c++) @(negedge clock);
    chk("rstmid_first_beat", {we_out, address_out, be_out, data_out}, {1'b1, beat(32'h10, 4'hC, 32'hB0A00000)});
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_count = 0;
    last_err = 3'd0;
    chk("rstmid_we_out", 68'(we_out), 68'd0);
    chk("rstmid_beat", {address_out, be_out, data_out}, 68'd0);
    chk("rstmid_ready", 68'(ready_in), 68'd1);
    chk("rstmid_record_count", 68'(record_count), 68'd0);
    chk("rstmid_error_code", 68'(error_code), 68'd0);
    @(negedge clock);
    chk("rstmid_no_resume", 68'(we_out), 68'd0);

    exp_q.push_back(beat(32'h10, 4'hF, 32'h04030201));
    send_line(":0400100001020304E2\n");
    collect();
    exp_count++;
    chk("post_rst_record_count", 68'(record_count), 68'(exp_count));
    chk("post_rst_beats_left", 68'(exp_q.size()), 68'd0);
    chk("post_rst_line_error", 68'(seen_err), 68'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
